// File: rtl/pla_seq_eval_if.sv
// Handshake and configuration bundle for pla_seq_eval: vector in, result out,
// cube-table write port and status.
interface pla_seq_eval_if #(
  parameter int NUM_IN    = 7,
  parameter int NUM_OUT   = 10,
  parameter int NUM_TERMS = 64
);
  localparam int AW = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;

  logic                  cfg_we;
  logic [AW-1:0]         cfg_addr;
  logic [2*NUM_IN-1:0]   cfg_in_mask;
  logic [NUM_OUT-1:0]    cfg_out_mask;
  logic                  cfg_en;
  logic                  cfg_err;

  logic                  in_valid;
  logic                  in_ready;
  logic [NUM_IN-1:0]     in_x;

  logic                  out_valid;
  logic                  out_ready;
  logic [NUM_OUT-1:0]    out_z;

  logic                  busy;

  modport master (
    output cfg_we, cfg_addr, cfg_in_mask, cfg_out_mask, cfg_en,
    output in_valid, in_x, out_ready,
    input  cfg_err, in_ready, out_valid, out_z, busy
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_in_mask, cfg_out_mask, cfg_en,
    input  in_valid, in_x, out_ready,
    output cfg_err, in_ready, out_valid, out_z, busy
  );
endinterface

// File: rtl/pla_seq_eval.sv
// Run-time programmable sum-of-products PLA: the cube table is scanned
// TERMS_PER_CYCLE terms per cycle, with valid/ready on input and result.
module pla_seq_eval #(
  parameter int                 NUM_IN          = 7,
  parameter int                 NUM_OUT         = 10,
  parameter int                 NUM_TERMS       = 64,
  parameter int                 TERMS_PER_CYCLE = 4,
  parameter logic [NUM_OUT-1:0] OUT_PHASE       = {NUM_OUT{1'b0}}
) (
  input  logic           clk,
  input  logic           rst_n,
  pla_seq_eval_if.slave  bus
);

  // NUM_TERMS must be a multiple of TERMS_PER_CYCLE; the scan walks whole groups.
  localparam int NUM_GROUPS = NUM_TERMS / TERMS_PER_CYCLE;
  localparam int AW         = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam int GW         = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [GW-1:0] LAST_GRP = GW'(NUM_GROUPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_IN-1:0]    x_q, x_d;
  logic [NUM_OUT-1:0]   acc_q, acc_d;
  logic [GW-1:0]        grp_q, grp_d;
  logic [NUM_OUT-1:0]   out_z_q, out_z_d;
  logic                 out_valid_q;
  logic                 in_ready_q;
  logic                 busy_q;
  logic                 cfg_err_q;

  logic [NUM_TERMS-1:0] en_q;
  logic [2*NUM_IN-1:0]  in_mask_q  [NUM_TERMS];
  logic [NUM_OUT-1:0]   out_mask_q [NUM_TERMS];

  logic [NUM_OUT-1:0]   contrib_s;
  logic                 accept_s;
  logic                 wr_en_s;

  // Field encoding per input: bit 0 admits x=0, bit 1 admits x=1 (00 never matches).
  function automatic logic term_match(input logic [2*NUM_IN-1:0] mask,
                                      input logic [NUM_IN-1:0]   x);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (x[i]) begin
        ok = ok & mask[2*i+1];
      end else begin
        ok = ok & mask[2*i];
      end
    end
    return ok;
  endfunction

  assign accept_s = bus.in_valid && in_ready_q;
  assign wr_en_s  = bus.cfg_we && (state_q == ST_IDLE);

  // OR-plane contribution of the group currently selected by grp_q.
  always_comb begin
    logic [AW-1:0] idx_v;
    idx_v     = {AW{1'b0}};
    contrib_s = {NUM_OUT{1'b0}};
    for (int t = 0; t < TERMS_PER_CYCLE; t++) begin
      idx_v = AW'(int'(grp_q) * TERMS_PER_CYCLE + t);
      if (en_q[idx_v] && term_match(in_mask_q[idx_v], x_q)) begin
        contrib_s = contrib_s | out_mask_q[idx_v];
      end else begin
        contrib_s = contrib_s;
      end
    end
  end

  // Next-state and datapath updates for the IDLE/SCAN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    acc_d   = acc_q;
    grp_d   = grp_q;
    out_z_d = out_z_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_SCAN;
          x_d     = bus.in_x;
          acc_d   = {NUM_OUT{1'b0}};
          grp_d   = {GW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        acc_d = acc_q | contrib_s;
        if (grp_q == LAST_GRP) begin
          state_d = ST_DONE;
          grp_d   = {GW{1'b0}};
          out_z_d = (acc_q | contrib_s) ^ OUT_PHASE;
        end else begin
          grp_d   = grp_q + {{(GW-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state plus handshake flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x_q         <= {NUM_IN{1'b0}};
      acc_q       <= {NUM_OUT{1'b0}};
      grp_q       <= {GW{1'b0}};
      out_z_q     <= {NUM_OUT{1'b0}};
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      acc_q       <= acc_d;
      grp_q       <= grp_d;
      out_z_q     <= out_z_d;
      out_valid_q <= (state_d == ST_DONE);
      in_ready_q  <= (state_d == ST_IDLE);
      busy_q      <= (state_d != ST_IDLE);
      cfg_err_q   <= bus.cfg_we && (state_q != ST_IDLE);
    end
  end

  // Term enables are the only table state cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= {NUM_TERMS{1'b0}};
    end else if (wr_en_s) begin
      en_q[bus.cfg_addr] <= bus.cfg_en;
    end else begin
      en_q <= en_q;
    end
  end

  // Cube and OR-plane masks; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      in_mask_q[bus.cfg_addr]  <= bus.cfg_in_mask;
      out_mask_q[bus.cfg_addr] <= bus.cfg_out_mask;
    end
  end

  assign bus.out_z     = out_z_q;
  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule
